// File: rtl/mirfak_pkg.sv
// Shared encodings and sizing for the Mirfak multiplier arbiter.
package mirfak_pkg;

    typedef enum logic [1:0] {
        CmdMul    = 2'b00,
        CmdMulh   = 2'b01,
        CmdMulhsu = 2'b10,
        CmdMulhu  = 2'b11
    } mult_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } arb_state_e;

    localparam int unsigned NumPorts      = 2;
    localparam int unsigned PortIdW       = 1;
    localparam int unsigned AckTimeoutMax = 255;
    localparam int unsigned WdogW         = $clog2(AckTimeoutMax + 1);

endpackage

// File: rtl/mirfak_mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the Mirfak multiplier arbiter.
interface mirfak_mult_arbiter_if;
    import mirfak_pkg::*;

    logic [NumPorts-1:0]   req_valid_i;
    logic [NumPorts-1:0]   req_ready_o;
    logic [32*NumPorts-1:0] req_op1_i;
    logic [32*NumPorts-1:0] req_op2_i;
    logic [2*NumPorts-1:0] req_cmd_i;
    logic                  kill_i;
    logic [NumPorts-1:0]   rsp_valid_o;
    logic [NumPorts-1:0]   rsp_ready_i;
    logic [31:0]           rsp_result_o;
    logic                  rsp_err_o;
    logic [31:0]           mult_op1_o;
    logic [31:0]           mult_op2_o;
    logic [1:0]            mult_cmd_o;
    logic                  mult_enable_o;
    logic [31:0]           mult_result_i;
    logic                  mult_ack_i;

    // The arbiter side.
    modport slave (
        input  req_valid_i, req_op1_i, req_op2_i, req_cmd_i, kill_i, rsp_ready_i,
               mult_result_i, mult_ack_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
               mult_op1_o, mult_op2_o, mult_cmd_o, mult_enable_o
    );

    // Requesters plus multiplier, seen from outside the arbiter.
    modport master (
        output req_valid_i, req_op1_i, req_op2_i, req_cmd_i, kill_i, rsp_ready_i,
               mult_result_i, mult_ack_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
               mult_op1_o, mult_op2_o, mult_cmd_o, mult_enable_o
    );

endinterface

// File: rtl/mirfak_rr_arbiter.sv
// Two-way request arbiter: round-robin when MIRFAK_MULT_ARB_RR_EN is defined,
// otherwise fixed priority with port 0 winning.
module mirfak_rr_arbiter
    import mirfak_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req_i,
    input  logic                accept_i,
    output logic [NumPorts-1:0] gnt_o
);

`ifdef MIRFAK_MULT_ARB_RR_EN
    logic [PortIdW-1:0] last_q, last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
        end
    end

    assign last_d = accept_i ? gnt_o[1] : last_q;

    // Reset to port 1 so that port 0 wins the first contested round.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk_i, rst_ni, accept_i};

    always_comb begin
        gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
    end
`endif

endmodule

// File: rtl/mirfak_mult_arbiter.sv
// Shares the Mirfak multiplier between two requesters with ack watchdog and kill.
// Arbitration policy is selected by MIRFAK_MULT_ARB_RR_EN (see mirfak_rr_arbiter).
module mirfak_mult_arbiter
    import mirfak_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    mirfak_mult_arbiter_if.slave bus
);

    localparam logic [WdogW-1:0] TimeoutCnt = WdogW'(ACK_TIMEOUT);

    arb_state_e          state_q, state_d;
    logic [31:0]         op1_q, op1_d;
    logic [31:0]         op2_q, op2_d;
    logic [31:0]         res_q, res_d;
    mult_cmd_e           cmd_q, cmd_d;
    logic [PortIdW-1:0]  id_q, id_d;
    logic                err_q, err_d;
    logic [WdogW-1:0]    wdog_q, wdog_d;
    logic [NumPorts-1:0] gnt;
    logic [NumPorts-1:0] ready;
    logic                accept;
    logic                win;
    logic                timeout;

    mirfak_rr_arbiter u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (bus.req_valid_i),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign ready   = (state_q == StIdle) ? gnt : 2'b00;
    assign accept  = |(bus.req_valid_i & ready);
    assign win     = ready[1];
    assign timeout = (wdog_q == TimeoutCnt);

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cmd_d   = cmd_q;
        id_d    = id_q;
        res_d   = res_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op1_d   = win ? bus.req_op1_i[63:32] : bus.req_op1_i[31:0];
                    op2_d   = win ? bus.req_op2_i[63:32] : bus.req_op2_i[31:0];
                    cmd_d   = mult_cmd_e'(win ? bus.req_cmd_i[3:2] : bus.req_cmd_i[1:0]);
                    id_d    = win;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = bus.kill_i ? StDrain : StWait;
            end
            StWait: begin
                // A kill coinciding with the ack or timeout ends the operation outright.
                if (bus.mult_ack_i || timeout) begin
                    if (bus.kill_i) begin
                        state_d = StIdle;
                    end else begin
                        res_d   = bus.mult_ack_i ? bus.mult_result_i : 32'h0;
                        err_d   = !bus.mult_ack_i;
                        state_d = StResp;
                    end
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                    if (bus.kill_i) begin
                        state_d = StDrain;
                    end
                end
            end
            StResp: begin
                if (bus.kill_i || bus.rsp_ready_i[id_q]) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (bus.mult_ack_i || timeout) begin
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op1_q   <= '0;
            op2_q   <= '0;
            cmd_q   <= CmdMul;
            id_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cmd_q   <= cmd_d;
            id_q    <= id_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.req_ready_o   = ready;
    assign bus.rsp_valid_o   = (state_q == StResp && !bus.kill_i) ?
                               ((id_q == 1'b1) ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result_o  = res_q;
    assign bus.rsp_err_o     = err_q;
    // Operands stay driven from the latches so the multiplier can resample them at ack.
    assign bus.mult_op1_o    = op1_q;
    assign bus.mult_op2_o    = op2_q;
    assign bus.mult_cmd_o    = cmd_q;
    assign bus.mult_enable_o = (state_q == StIssue);

endmodule

// File: tb/tb_mirfak_mult_arbiter.sv
// Self-checking bench for mirfak_mult_arbiter with a 3-cycle multiplier stub.
module tb_mirfak_mult_arbiter;

    localparam int unsigned AckTo = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    mirfak_mult_arbiter_if bus ();

    mirfak_mult_arbiter #(
        .ACK_TIMEOUT (AckTo)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int exp_last = 1;
    bit stub_ack_en = 1'b1;
    logic [2:0] en_pipe = 3'b000;

    // Architectural RISC-V style multiply result.
    function automatic logic [31:0] ref_mul(input logic [1:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, za, sb, zb, p;
        sa = {{32{a[31]}}, a};
        za = {32'h0, a};
        sb = {{32{b[31]}}, b};
        zb = {32'h0, b};
        case (cmd)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * zb;
            default: p = za * zb;
        endcase
        return (cmd == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stub: acks three cycles after enable and computes from the
    // operands present at ack time; it is never reset with the arbiter.
    always @(posedge clk_i) en_pipe <= {en_pipe[1:0], bus.mult_enable_o};
    assign bus.mult_ack_i    = en_pipe[2] & stub_ack_en;
    assign bus.mult_result_i = en_pipe[2] ?
        ref_mul(bus.mult_cmd_o, bus.mult_op1_o, bus.mult_op2_o) : 32'hDEAD_BEEF;

    task automatic issue_req(input logic [1:0] mask, input int port, input logic [1:0] cmd,
                             input logic [31:0] a, input logic [31:0] b, input int exp_wait,
                             input string name);
        int waited = 0;
        @(posedge clk_i); #1;
        bus.req_op1_i = {$urandom, $urandom};
        bus.req_op2_i = {$urandom, $urandom};
        bus.req_cmd_i = 4'($urandom);
        bus.req_op1_i[port*32 +: 32] = a;
        bus.req_op2_i[port*32 +: 32] = b;
        bus.req_cmd_i[port*2 +: 2]   = cmd;
        bus.req_valid_i = mask;
        @(negedge clk_i);
        while (bus.req_ready_o == 2'b00 && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        n_cmp++;
        if (bus.req_ready_o !== 2'(1 << port) || waited != exp_wait) begin
            n_err++;
            $display("FAIL %s accept: ready=%b after %0d waits, required %b after %0d",
                     name, bus.req_ready_o, waited, 2'(1 << port), exp_wait);
        end
        exp_last = port;
        @(posedge clk_i); #1;
        bus.req_valid_i = 2'b00;
        @(negedge clk_i);
        n_cmp++;
        if (bus.mult_enable_o !== 1'b1 || bus.mult_op1_o !== a || bus.mult_op2_o !== b ||
            bus.mult_cmd_o !== cmd) begin
            n_err++;
            $display("FAIL %s issue: en=%b op1=%h op2=%h cmd=%b, required 1 %h %h %b",
                     name, bus.mult_enable_o, bus.mult_op1_o, bus.mult_op2_o, bus.mult_cmd_o,
                     a, b, cmd);
        end
    endtask

    // Entered at the falling edge of the ISSUE cycle (cycle 1 after accept).
    task automatic wait_rsp(input int port, input logic [31:0] exp_res, input logic exp_err,
                            input int exp_at, input int stall, input string name);
        int t = 1;
        bus.rsp_ready_i = (stall == 0) ? 2'b11 : (2'b11 & ~2'(1 << port));
        do begin
            @(posedge clk_i); #1;
            t++;
            @(negedge clk_i);
            if (t == 2) begin
                n_cmp++;
                if (bus.mult_enable_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s enable_pulse: enable=%b in cycle 2, required 0",
                             name, bus.mult_enable_o);
                end
            end
        end while (bus.rsp_valid_o == 2'b00 && t < 60);
        n_cmp++;
        if (bus.rsp_valid_o !== 2'(1 << port) || t != exp_at || bus.rsp_result_o !== exp_res ||
            bus.rsp_err_o !== exp_err) begin
            n_err++;
            $display("FAIL %s rsp: valid=%b cycle=%0d result=%h err=%b, required %b %0d %h %b",
                     name, bus.rsp_valid_o, t, bus.rsp_result_o, bus.rsp_err_o,
                     2'(1 << port), exp_at, exp_res, exp_err);
        end
        for (int s = 1; s <= stall; s++) begin
            @(posedge clk_i); #1;
            if (s == stall) bus.rsp_ready_i = 2'b11;
            @(negedge clk_i);
            n_cmp++;
            if (bus.rsp_valid_o !== 2'(1 << port) || bus.rsp_result_o !== exp_res) begin
                n_err++;
                $display("FAIL %s hold: valid=%b result=%h, required %b %h",
                         name, bus.rsp_valid_o, bus.rsp_result_o, 2'(1 << port), exp_res);
            end
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_cmp++;
        if (bus.rsp_valid_o !== 2'b00) begin
            n_err++;
            $display("FAIL %s release: valid=%b, required 00", name, bus.rsp_valid_o);
        end
    endtask

    task automatic test_reset();
        logic [103:0] outs;
        #12;
        outs = {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_err_o,
                bus.mult_op1_o, bus.mult_op2_o, bus.mult_cmd_o, bus.mult_enable_o};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_directed();
        issue_req(2'b01, 0, 2'b00, 32'd7, 32'd6, 0, "mul7x6");
        wait_rsp(0, 32'h0000_002A, 1'b0, 5, 0, "mul7x6");
        issue_req(2'b10, 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        wait_rsp(1, 32'hFFFF_FFFE, 1'b0, 5, 2, "mulhu");
        issue_req(2'b10, 1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, "mulh");
        wait_rsp(1, 32'hFFFF_FFFF, 1'b0, 5, 0, "mulh");
        issue_req(2'b01, 0, 2'b10, 32'h8000_0000, 32'h0000_0004, 0, "mulhsu");
        wait_rsp(0, 32'hFFFF_FFFE, 1'b0, 5, 1, "mulhsu");
    endtask

    task automatic test_arbitration();
        int grants[$];
        int gcyc[$];
        int t = 0;
        int exp_port;
        bus.rsp_ready_i = 2'b11;
        @(posedge clk_i); #1;
        bus.req_op1_i   = {$urandom, $urandom};
        bus.req_op2_i   = {$urandom, $urandom};
        bus.req_cmd_i   = 4'($urandom);
        bus.req_valid_i = 2'b11;
        while (grants.size() < 4 && t < 80) begin
            @(negedge clk_i);
            if (bus.req_ready_o != 2'b00) begin
                grants.push_back(bus.req_ready_o == 2'b01 ? 0 : (bus.req_ready_o == 2'b10 ? 1 : 9));
                gcyc.push_back(t);
            end
            @(posedge clk_i); #1;
            t++;
        end
        bus.req_valid_i = 2'b00;
        n_cmp++;
        if (grants.size() != 4) begin
            n_err++;
            $display("FAIL arb_count: %0d grants, required 4", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
`ifdef MIRFAK_MULT_ARB_RR_EN
            exp_port = (exp_last == 1) ? 0 : 1;
`else
            exp_port = 0;
`endif
            exp_last = exp_port;
            n_cmp++;
            if (grants[i] != exp_port || (i > 0 && gcyc[i] - gcyc[i-1] != 6)) begin
                n_err++;
                $display("FAIL arb_grant%0d: port %0d spacing %0d, required port %0d spacing 6",
                         i, grants[i], (i > 0) ? gcyc[i] - gcyc[i-1] : 6, exp_port);
            end
        end
        repeat (8) @(posedge clk_i);
    endtask

    task automatic test_timeout();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        stub_ack_en = 1'b0;
        issue_req(2'b10, 1, 2'b11, a, b, 0, "timeout");
        wait_rsp(1, 32'h0, 1'b1, AckTo + 3, 1, "timeout");
        stub_ack_en = 1'b1;
        issue_req(2'b01, 0, 2'b00, b, a, 0, "after_timeout");
        wait_rsp(0, ref_mul(2'b00, b, a), 1'b0, 5, 0, "after_timeout");
    endtask

    task automatic test_kill_wait();
        logic [31:0] c, d;
        logic [1:0] cmd;
        int t;
        int ready_at = -1;
        bit saw_rsp = 1'b0;
        c   = $urandom;
        d   = $urandom;
        cmd = 2'($urandom);
        issue_req(2'b01, 0, 2'b00, 32'($urandom), 32'($urandom), 0, "kill_op");
        bus.rsp_ready_i = 2'b11;
        @(posedge clk_i); #1;
        bus.kill_i = 1'b1;
        @(posedge clk_i); #1;
        bus.kill_i      = 1'b0;
        bus.req_op1_i   = {c, 32'($urandom)};
        bus.req_op2_i   = {d, 32'($urandom)};
        bus.req_cmd_i   = {cmd, 2'b00};
        bus.req_valid_i = 2'b10;
        t = 3;
        while (ready_at < 0 && t < 20) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o != 2'b00) saw_rsp = 1'b1;
            if (bus.req_ready_o != 2'b00) begin
                ready_at = t;
            end else begin
                @(posedge clk_i); #1;
                t++;
            end
        end
        n_cmp++;
        if (saw_rsp) begin
            n_err++;
            $display("FAIL kill_no_rsp: response seen after kill, required none");
        end
        n_cmp++;
        if (ready_at != 5 || bus.req_ready_o !== 2'b10) begin
            n_err++;
            $display("FAIL kill_reaccept: ready=%b in cycle %0d, required 10 in cycle 5",
                     bus.req_ready_o, ready_at);
        end
        exp_last = 1;
        @(posedge clk_i); #1;
        bus.req_valid_i = 2'b00;
        @(negedge clk_i);
        wait_rsp(1, ref_mul(cmd, c, d), 1'b0, 5, 0, "post_kill");
    endtask

    task automatic test_kill_resp();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        issue_req(2'b01, 0, 2'b00, a, b, 0, "kill_resp");
        bus.rsp_ready_i = 2'b00;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (bus.rsp_valid_o !== 2'b01) begin
            n_err++;
            $display("FAIL kill_resp_valid: valid=%b, required 01", bus.rsp_valid_o);
        end
        @(posedge clk_i); #1;
        bus.kill_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (bus.rsp_valid_o !== 2'b00) begin
            n_err++;
            $display("FAIL kill_resp_mask: valid=%b, required 00", bus.rsp_valid_o);
        end
        @(posedge clk_i); #1;
        bus.kill_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (bus.rsp_valid_o !== 2'b00) begin
            n_err++;
            $display("FAIL kill_resp_drop: valid=%b after kill, required 00", bus.rsp_valid_o);
        end
        issue_req(2'b10, 1, 2'b01, b, a, 0, "after_kill_resp");
        wait_rsp(1, ref_mul(2'b01, b, a), 1'b0, 5, 0, "after_kill_resp");
    endtask

    task automatic test_reset_mid_op();
        logic [103:0] outs;
        bit saw_rsp = 1'b0;
        issue_req(2'b01, 0, 2'b11, 32'($urandom), 32'($urandom), 0, "reset_op");
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        outs = {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_err_o,
                bus.mult_op1_o, bus.mult_op2_o, bus.mult_cmd_o, bus.mult_enable_o};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_mid_op: outputs %h, required 0", outs);
        end
        @(negedge clk_i);
        rst_ni   = 1'b1;
        exp_last = 1;
        bus.rsp_ready_i = 2'b11;
        repeat (5) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o != 2'b00) saw_rsp = 1'b1;
        end
        n_cmp++;
        if (saw_rsp) begin
            n_err++;
            $display("FAIL stale_ack: response after reset, required none");
        end
        issue_req(2'b01, 0, 2'b00, 32'd3, 32'd5, 0, "post_reset");
        wait_rsp(0, 32'd15, 1'b0, 5, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [1:0] mask;
            logic [1:0] cmd;
            logic [31:0] a, b;
            int port;
            mask = 2'($urandom_range(1, 3));
            cmd  = 2'($urandom);
            a    = (i % 4 == 0) ? 32'h8000_0000 : 32'($urandom);
            b    = $urandom;
            if (mask == 2'b11) begin
`ifdef MIRFAK_MULT_ARB_RR_EN
                port = (exp_last == 1) ? 0 : 1;
`else
                port = 0;
`endif
            end else begin
                port = (mask == 2'b10) ? 1 : 0;
            end
            issue_req(mask, port, cmd, a, b, 0, "random");
            wait_rsp(port, ref_mul(cmd, a, b), 1'b0, 5, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        bus.req_valid_i = 2'b00;
        bus.req_op1_i   = '0;
        bus.req_op2_i   = '0;
        bus.req_cmd_i   = '0;
        bus.kill_i      = 1'b0;
        bus.rsp_ready_i = 2'b00;
        test_reset();
        test_directed();
        test_arbitration();
        test_timeout();
        test_kill_wait();
        test_kill_resp();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

endmodule
